reg_file_2r1w: RTL and testbench

- Architectural general-purpose register file for the RISC CPU datapath.
- Sits directly upstream of the 32-bit ALU-source 2:1 mux: rd_data2 feeds that mux's "a" input, and the sign-extended immediate feeds its "b" input. rd_data1 feeds the ALU directly.
- Two asynchronous read ports, one synchronous write port from writeback.
- Register 0 is hardwired to zero. A same-cycle write-to-read bypass is included so that single-cycle and pipelined datapaths see the newest value.

---
 rtl/reg_file_2r1w.sv | 84 ++++++++
 tb/tb_reg_file_2r1w.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// Purpose : 32-entry architectural register file with two combinational read ports
//           and one write port. Register 0 always reads zero. A write is visible
//           on the read ports in the same cycle it is presented.
// Latency : reads are zero-cycle (combinational); writes commit on the rising clk edge.
// Backpressure : none; a write is accepted every cycle and reads are always valid.
//
// Ports:
//   clk                 clock; all state updates on the rising edge
//   rst                 synchronous active-high reset; clears every register
//   rd_addr1/rd_data1   read port 1 (rs), feeds the ALU directly
//   rd_addr2/rd_data2   read port 2 (rt), feeds the ALU-source mux "a" input
//   wr_en/wr_addr/wr_data  writeback port
module reg_file_2r1w #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] rd_addr1,
   input  logic [ADDR_WIDTH-1:0] rd_addr2,
   output logic [DATA_WIDTH-1:0] rd_data1,
   output logic [DATA_WIDTH-1:0] rd_data2,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   // Entry 0 has no storage at all; it is synthesised as a constant zero on read.
   logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
   logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

   logic wr_commit;   // write that will actually land in storage
   logic bypass_en;   // same-cycle forwarding allowed (never during reset)

   assign wr_commit = wr_en && (wr_addr != '0);
   assign bypass_en = wr_commit && !rst;

   // Next-state: only the addressed entry changes.
   always_comb begin
      for (int i = 1; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_commit && (wr_addr == ADDR_WIDTH'(i))) begin
            regs_d[i] = wr_data;
         end
      end
   end

   // Reset takes priority over a simultaneous write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read ports: address 0 falls through every compare and yields zero; the
   // bypass compare is gated by wr_commit, so a write to 0 never forwards.
   always_comb begin
      rd_data1 = '0;
      rd_data2 = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (rd_addr1 == ADDR_WIDTH'(i)) begin
            rd_data1 = regs_q[i];
         end
         if (rd_addr2 == ADDR_WIDTH'(i)) begin
            rd_data2 = regs_q[i];
         end
      end
      if (bypass_en && (wr_addr == rd_addr1)) begin
         rd_data1 = wr_data;
      end
      if (bypass_en && (wr_addr == rd_addr2)) begin
         rd_data2 = wr_data;
      end
   end

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

   logic        clk;
   logic        rst;
   logic [4:0]  rd_addr1;
   logic [4:0]  rd_addr2;
   logic [31:0] rd_data1;
   logic [31:0] rd_data2;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int n_tests;
   int n_fail;

   reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        wr_en;
      logic [4:0]  wr_addr;
      logic [31:0] wr_data;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [31:0] e1,
                               input logic [31:0] e2);
      vec_t v;
      v.rst = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
      v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge; outputs settle
   // well before the next rising edge commits the cycle.
   task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk);
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
      rd_addr1 = a1; rd_addr2 = a2;
      #2;
   endtask

   // Reference model: architectural register contents plus the read rule.
   logic [31:0] model [32];

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (!rst && wr_en && wr_addr == a) return wr_data;
      return model[a];
   endfunction

   task automatic model_commit();
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (wr_en && wr_addr != 5'd0) begin
         model[wr_addr] = wr_data;
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr1 = '0; rd_addr2 = '0;

      // Address 0 reads zero even before any reset.
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      check("pre_reset_r0_p1", rd_data1, 32'h0);
      check("pre_reset_r0_p2", rd_data2, 32'h0);

      // Initial reset.
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      // Hand-computed vectors; each row is one cycle, checked before its edge.
      vecs[0]  = mk(0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
      vecs[1]  = mk(1, 0, 5'd0, 32'h0,        5'd5, 5'd6, 32'hDEADBEEF, 32'h0);
      vecs[2]  = mk(0, 0, 5'd0, 32'h0,        5'd5, 5'd31, 32'h0, 32'h0);
      vecs[3]  = mk(0, 1, 5'd7, 32'h12345678, 5'd7, 5'd8, 32'h12345678, 32'h0);
      vecs[4]  = mk(0, 0, 5'd0, 32'h0,        5'd7, 5'd7, 32'h12345678, 32'h12345678);
      vecs[5]  = mk(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 32'h0, 32'h12345678);
      vecs[6]  = mk(0, 0, 5'd0, 32'h0,        5'd0, 5'd8, 32'h0, 32'h0);
      vecs[7]  = mk(0, 1, 5'd3, 32'h00000011, 5'd3, 5'd4, 32'h00000011, 32'h0);
      vecs[8]  = mk(0, 1, 5'd4, 32'h00000044, 5'd3, 5'd4, 32'h00000011, 32'h00000044);
      vecs[9]  = mk(0, 1, 5'd3, 32'h00000022, 5'd3, 5'd4, 32'h00000022, 32'h00000044);
      vecs[10] = mk(0, 0, 5'd0, 32'h0,        5'd3, 5'd4, 32'h00000022, 32'h00000044);
      vecs[11] = mk(0, 1, 5'd9, 32'h00009999, 5'd9, 5'd9, 32'h00009999, 32'h00009999);
      vecs[12] = mk(1, 1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd3, 32'h00009999, 32'h00000022);
      vecs[13] = mk(0, 0, 5'd0, 32'h0,        5'd9, 5'd3, 32'h0, 32'h0);

      for (int v = 0; v < 14; v++) begin
         drive(vecs[v].rst, vecs[v].wr_en, vecs[v].wr_addr, vecs[v].wr_data,
               vecs[v].a1, vecs[v].a2);
         check($sformatf("vec%0d_p1", v), rd_data1, vecs[v].e1);
         check($sformatf("vec%0d_p2", v), rd_data2, vecs[v].e2);
      end

      // After the reset in the table, every address reads zero.
      for (int a = 0; a < 32; a++) begin
         drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
         check($sformatf("post_reset_a%0d", a), rd_data1, 32'h0);
         check($sformatf("post_reset_b%0d", 31 - a), rd_data2, 32'h0);
      end

      // Full sweep: R[i] = i*0x01010101, then read pairs (i, 32-i).
      for (int i = 1; i < 32; i++) begin
         drive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'd0);
         check($sformatf("sweep_wr%0d", i), rd_data1, 32'(i) * 32'h01010101);
      end
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
         check($sformatf("sweep_rd1_%0d", i), rd_data1, 32'(i) * 32'h01010101);
         check($sformatf("sweep_rd2_%0d", (32 - i) % 32), rd_data2,
               32'((32 - i) % 32) * 32'h01010101);
      end

      // Randomised phase against the reference model, starting from a reset.
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      model_commit();
      for (int c = 0; c < 600; c++) begin
         logic        r;
         logic        we;
         logic [4:0]  wa;
         logic [31:0] wd;
         logic [4:0]  a1;
         logic [4:0]  a2;
         r  = ($urandom_range(0, 39) == 0);
         we = ($urandom_range(0, 3) != 0);
         wa = 5'($urandom_range(0, 31));
         wd = $urandom;
         a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         drive(r, we, wa, wd, a1, a2);
         check($sformatf("rand%0d_p1", c), rd_data1, model_read(a1));
         check($sformatf("rand%0d_p2", c), rd_data2, model_read(a2));
         model_commit();
      end

      // Final readback of every register against the model.
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      for (int a = 0; a < 32; a++) begin
         drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(a));
         check($sformatf("final_a%0d", a), rd_data1, model_read(5'(a)));
         check($sformatf("final_b%0d", a), rd_data2, model_read(5'(a)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
